// File: rtl/lsu.sv
// Load/store unit: accepts one execute-stage op at a time, runs a single bus access with timeout, returns writeback.
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of truncating the address.
module lsu #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_Valid_1,
  output logic        o_Ready_1,
  input  logic        i_MemRead_1,
  input  logic        i_MemWrite_1,
  input  logic [2:0]  i_Funct3_3,
  input  logic [31:0] i_ALUResult_32,
  input  logic [31:0] i_StoreData_32,
  output logic        o_MemReq_1,
  output logic        o_MemWe_1,
  output logic [31:0] o_MemAddr_32,
  output logic [3:0]  o_MemWstrb_4,
  output logic [31:0] o_MemWdata_32,
  input  logic        i_MemAck_1,
  input  logic [31:0] i_MemRdata_32,
  output logic        o_WbValid_1,
  output logic [31:0] o_WbData_32,
  output logic        o_Misaligned_1,
  output logic        o_BusErr_1
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(ACK_TIMEOUT - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [2:0]  funct3_q;
  logic [1:0]  offset_q;

  logic        is_store;
  logic        is_mem;
  logic [1:0]  size;
  logic [1:0]  offset;
  logic        trap;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic [31:0] lane;
  logic [31:0] load_data;

  // Decode the incoming op: a store wins when both read and write are set; size 0/1/2 = byte/half/word.
  always_comb begin
    is_store = i_MemWrite_1;
    is_mem   = i_MemRead_1 | i_MemWrite_1;
    size     = 2'd2;
    if (is_store) begin
      case (i_Funct3_3)
        3'b000:  size = 2'd0;
        3'b001:  size = 2'd1;
        default: size = 2'd2;
      endcase
    end else begin
      case (i_Funct3_3)
        3'b000, 3'b100: size = 2'd0;
        3'b001, 3'b101: size = 2'd1;
        default:        size = 2'd2;
      endcase
    end

    case (size)
      2'd0:    offset = i_ALUResult_32[1:0];
      2'd1:    offset = {i_ALUResult_32[1], 1'b0};
      default: offset = 2'b00;
    endcase

`ifdef LSU_MISALIGN_TRAP_EN
    trap = is_mem & (((size == 2'd1) & i_ALUResult_32[0]) |
                     ((size == 2'd2) & (i_ALUResult_32[1:0] != 2'b00)));
`else
    trap = 1'b0;
`endif

    case (size)
      2'd0: begin
        wstrb = 4'b0001 << offset;
        wdata = {4{i_StoreData_32[7:0]}};
      end
      2'd1: begin
        wstrb = 4'b0011 << offset;
        wdata = {2{i_StoreData_32[15:0]}};
      end
      default: begin
        wstrb = 4'b1111;
        wdata = i_StoreData_32;
      end
    endcase
  end

  // Lane-select and extend the read word in the acknowledge cycle.
  always_comb begin
    lane = i_MemRdata_32 >> {offset_q, 3'b000};
    case (funct3_q)
      3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
      3'b100:  load_data = {24'd0, lane[7:0]};
      3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
      3'b101:  load_data = {16'd0, lane[15:0]};
      default: load_data = lane;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      o_Ready_1     <= 1'b1;
      o_MemReq_1    <= 1'b0;
      o_MemWe_1     <= 1'b0;
      o_MemAddr_32  <= 32'd0;
      o_MemWstrb_4  <= 4'b0000;
      o_MemWdata_32 <= 32'd0;
      o_WbValid_1   <= 1'b0;
      o_WbData_32   <= 32'd0;
      o_BusErr_1    <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      o_Misaligned_1 <= 1'b0;
`endif
      wait_cnt      <= 8'd0;
      funct3_q      <= 3'd0;
      offset_q      <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (i_Valid_1) begin
            o_Ready_1     <= 1'b0;
            funct3_q      <= i_Funct3_3;
            offset_q      <= offset;
            wait_cnt      <= 8'd0;
            o_MemAddr_32  <= {i_ALUResult_32[31:2], 2'b00};
            o_MemWe_1     <= is_store & ~trap;
            o_MemWstrb_4  <= (is_store & ~trap) ? wstrb : 4'b0000;
            o_MemWdata_32 <= wdata;
            if (!is_mem || trap) begin
              state       <= DONE;
              o_WbValid_1 <= 1'b1;
              o_WbData_32 <= is_mem ? 32'd0 : i_ALUResult_32;
`ifdef LSU_MISALIGN_TRAP_EN
              o_Misaligned_1 <= trap;
`endif
            end else begin
              state      <= ACCESS;
              o_MemReq_1 <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (i_MemAck_1) begin
            state       <= DONE;
            o_MemReq_1  <= 1'b0;
            o_WbValid_1 <= 1'b1;
            o_WbData_32 <= o_MemWe_1 ? 32'd0 : load_data;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt == LAST_WAIT) begin
              state       <= DONE;
              o_MemReq_1  <= 1'b0;
              o_WbValid_1 <= 1'b1;
              o_WbData_32 <= 32'd0;
              o_BusErr_1  <= 1'b1;
            end
          end
        end
        DONE: begin
          state       <= IDLE;
          o_Ready_1   <= 1'b1;
          o_WbValid_1 <= 1'b0;
          o_BusErr_1  <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
          o_Misaligned_1 <= 1'b0;
`endif
        end
        default: begin
          state     <= IDLE;
          o_Ready_1 <= 1'b1;
        end
      endcase
    end
  end

`ifndef LSU_MISALIGN_TRAP_EN
  assign o_Misaligned_1 = 1'b0;
`endif

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized ops against a behavioural model.
module tb_lsu;

  localparam int TIMEOUT = 4;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        i_Valid_1;
  logic        o_Ready_1;
  logic        i_MemRead_1;
  logic        i_MemWrite_1;
  logic [2:0]  i_Funct3_3;
  logic [31:0] i_ALUResult_32;
  logic [31:0] i_StoreData_32;
  logic        o_MemReq_1;
  logic        o_MemWe_1;
  logic [31:0] o_MemAddr_32;
  logic [3:0]  o_MemWstrb_4;
  logic [31:0] o_MemWdata_32;
  logic        i_MemAck_1;
  logic [31:0] i_MemRdata_32;
  logic        o_WbValid_1;
  logic [31:0] o_WbData_32;
  logic        o_Misaligned_1;
  logic        o_BusErr_1;

  int n_tests = 0;
  int n_fail  = 0;

  lsu #(.ACK_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_Valid_1(i_Valid_1), .o_Ready_1(o_Ready_1),
    .i_MemRead_1(i_MemRead_1), .i_MemWrite_1(i_MemWrite_1),
    .i_Funct3_3(i_Funct3_3), .i_ALUResult_32(i_ALUResult_32), .i_StoreData_32(i_StoreData_32),
    .o_MemReq_1(o_MemReq_1), .o_MemWe_1(o_MemWe_1), .o_MemAddr_32(o_MemAddr_32),
    .o_MemWstrb_4(o_MemWstrb_4), .o_MemWdata_32(o_MemWdata_32),
    .i_MemAck_1(i_MemAck_1), .i_MemRdata_32(i_MemRdata_32),
    .o_WbValid_1(o_WbValid_1), .o_WbData_32(o_WbData_32),
    .o_Misaligned_1(o_Misaligned_1), .o_BusErr_1(o_BusErr_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ready0;
    int          ncyc;
    logic [69:0] bus;
    logic        stable;
    logic [3:0]  flags;
    logic [31:0] wbdata;
    logic [1:0]  after;
  } obs_t;

  typedef struct {
    int          ncyc;
    logic [37:0] bus_hi;
    logic [31:0] wdata;
    logic [3:0]  flags;
    logic [31:0] wbdata;
    logic        chk_wb;
    logic        store;
  } exp_t;

  // Reference: widths in bytes, lane offset by integer division, sign extension by subtraction.
  function automatic exp_t model(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] sd,
                                 input int ack_at, input logic [31:0] rdata);
    exp_t e;
    int w, off;
    logic mem, mis, trap, tout;
    logic [31:0] lane, val;
    logic [3:0] strb;
    mem = rd | wr;
    if (wr) w = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    else    w = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    off  = (int'(a[1:0]) / w) * w;
    mis  = (int'(a[1:0]) % w) != 0;
    trap = mem && mis && TRAP;
    tout = mem && !trap && (ack_at >= TIMEOUT);
    e.ncyc = (!mem || trap) ? 0 : (tout ? TIMEOUT : ack_at + 1);
    strb = wr ? 4'(((1 << w) - 1) << off) : 4'b0000;
    e.bus_hi = {1'b1, wr, strb, a[31:2], 2'b00};
    if (w == 1)      e.wdata = {24'd0, sd[7:0]} * 32'h0101_0101;
    else if (w == 2) e.wdata = {16'd0, sd[15:0]} * 32'h0001_0001;
    else             e.wdata = sd;
    lane = rdata >> (8 * off);
    if (w < 4) lane = lane & ((32'd1 << (8 * w)) - 32'd1);
    val = lane;
    if (w < 4 && !f3[2] && lane >= (32'd1 << (8 * w - 1))) val = lane - (32'd1 << (8 * w));
    e.flags  = {1'b1, trap, tout, 1'b0};
    e.wbdata = !mem ? a : (trap || tout) ? 32'd0 : val;
    e.chk_wb = !(wr && !trap && !tout);
    e.store  = wr;
    return e;
  endfunction

  // Issues one op from a negedge, acts as the memory, and records what the DUT did.
  task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] sd,
                        input int ack_at, input logic [31:0] rdata, output obs_t o);
    o.ready0 = o_Ready_1;
    i_Valid_1 = 1'b1; i_MemRead_1 = rd; i_MemWrite_1 = wr;
    i_Funct3_3 = f3; i_ALUResult_32 = alu; i_StoreData_32 = sd;
    @(negedge clk);
    i_Valid_1 = 1'b0;
    i_MemRead_1 = 1'($urandom); i_MemWrite_1 = 1'($urandom);
    i_Funct3_3 = 3'($urandom); i_ALUResult_32 = $urandom; i_StoreData_32 = $urandom;
    o.ncyc = 0; o.stable = 1'b1; o.bus = '0;
    while (o_MemReq_1 && o.ncyc < 20) begin
      if (o.ncyc == 0)
        o.bus = {o_MemReq_1, o_MemWe_1, o_MemWstrb_4, o_MemAddr_32, o_MemWdata_32};
      else if ({o_MemReq_1, o_MemWe_1, o_MemWstrb_4, o_MemAddr_32, o_MemWdata_32} !== o.bus)
        o.stable = 1'b0;
      i_MemAck_1    = (o.ncyc == ack_at);
      i_MemRdata_32 = (o.ncyc == ack_at) ? rdata : $urandom;
      @(negedge clk);
      i_MemAck_1 = 1'b0;
      o.ncyc++;
    end
    o.flags  = {o_WbValid_1, o_Misaligned_1, o_BusErr_1, o_MemReq_1};
    o.wbdata = o_WbData_32;
    i_MemAck_1 = 1'b1; i_MemRdata_32 = $urandom;
    @(negedge clk);
    i_MemAck_1 = 1'b0;
    o.after = {o_Ready_1, o_WbValid_1};
  endtask

  task automatic test_reset();
    i_Valid_1 = 0; i_MemRead_1 = 0; i_MemWrite_1 = 0; i_Funct3_3 = 0;
    i_ALUResult_32 = 0; i_StoreData_32 = 0; i_MemAck_1 = 0; i_MemRdata_32 = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({o_Ready_1, o_MemReq_1, o_MemWe_1, o_WbValid_1, o_Misaligned_1, o_BusErr_1,
         o_MemWstrb_4, o_MemAddr_32, o_MemWdata_32, o_WbData_32} !== {1'b1, 5'b0, 4'b0, 96'b0}) begin
      n_fail++;
      $display("[TB] FAIL reset_values: got ready=%b req=%b we=%b wbv=%b mis=%b berr=%b strb=%h addr=%h wdata=%h wbdata=%h, expected ready=1 and all else 0",
               o_Ready_1, o_MemReq_1, o_MemWe_1, o_WbValid_1, o_Misaligned_1, o_BusErr_1,
               o_MemWstrb_4, o_MemAddr_32, o_MemWdata_32, o_WbData_32);
    end
    i_MemAck_1 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    i_MemAck_1 = 1'b0;
    n_tests++;
    if ({o_Ready_1, o_WbValid_1, o_MemReq_1} !== 3'b100) begin
      n_fail++;
      $display("[TB] FAIL reset_release_idle: got ready/wbv/req=%b expected 100", {o_Ready_1, o_WbValid_1, o_MemReq_1});
    end
  endtask

  task automatic test_nonmem();
    obs_t o;
    run_op(1'b0, 1'b0, 3'd2, 32'h1234_5678, 32'hCAFE_0001, 0, 32'h0, o);
    n_tests++;
    if ({o.ready0, 8'(o.ncyc), o.flags, o.after} !== {1'b1, 8'd0, 4'b1000, 2'b10}) begin
      n_fail++;
      $display("[TB] FAIL nonmem_ctrl: got ready0=%b reqcycles=%0d flags=%b after=%b expected 1/0/1000/10",
               o.ready0, o.ncyc, o.flags, o.after);
    end
    n_tests++;
    if (o.wbdata !== 32'h1234_5678) begin
      n_fail++;
      $display("[TB] FAIL nonmem_wbdata: got %h expected 12345678", o.wbdata);
    end
  endtask

  task automatic test_store();
    obs_t o;
    run_op(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 1, 32'h0, o);
    n_tests++;
    if ({8'(o.ncyc), o.stable, o.flags, o.after} !== {8'd2, 1'b1, 4'b1000, 2'b10}) begin
      n_fail++;
      $display("[TB] FAIL sb_ctrl: got cycles=%0d stable=%b flags=%b after=%b expected 2/1/1000/10",
               o.ncyc, o.stable, o.flags, o.after);
    end
    n_tests++;
    if (o.bus !== {1'b1, 1'b1, 4'b1000, 32'h0000_1000, 32'hA5A5_A5A5}) begin
      n_fail++;
      $display("[TB] FAIL sb_bus: got %h expected req=1 we=1 strb=1000 addr=00001000 wdata=a5a5a5a5", o.bus);
    end
    run_op(1'b1, 1'b1, 3'b010, 32'h0000_0040, 32'hDEAD_BEEF, 0, 32'h0, o);
    n_tests++;
    if (o.bus !== {1'b1, 1'b1, 4'b1111, 32'h0000_0040, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("[TB] FAIL rdwr_as_store: got %h expected req=1 we=1 strb=1111 addr=00000040 wdata=deadbeef", o.bus);
    end
  endtask

  task automatic test_load_byte();
    obs_t o;
    run_op(1'b1, 1'b0, 3'b000, 32'h0000_2002, 32'h0, 0, 32'h0080_0000, o);
    n_tests++;
    if (o.bus[69:32] !== {1'b1, 1'b0, 4'b0000, 32'h0000_2000}) begin
      n_fail++;
      $display("[TB] FAIL lb_bus: got %h expected req=1 we=0 strb=0 addr=00002000", o.bus[69:32]);
    end
    n_tests++;
    if (o.wbdata !== 32'hFFFF_FF80) begin
      n_fail++;
      $display("[TB] FAIL lb_data: got %h expected ffffff80", o.wbdata);
    end
    run_op(1'b1, 1'b0, 3'b100, 32'h0000_2002, 32'h0, 0, 32'h0080_0000, o);
    n_tests++;
    if (o.wbdata !== 32'h0000_0080) begin
      n_fail++;
      $display("[TB] FAIL lbu_data: got %h expected 00000080", o.wbdata);
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 99, 32'h0, o);
    n_tests++;
    if ({8'(o.ncyc), o.flags, o.after} !== {8'd4, 4'b1010, 2'b10}) begin
      n_fail++;
      $display("[TB] FAIL timeout_ctrl: got cycles=%0d flags=%b after=%b expected 4/1010/10", o.ncyc, o.flags, o.after);
    end
    n_tests++;
    if (o.wbdata !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL timeout_wbdata: got %h expected 00000000", o.wbdata);
    end
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0, 3, 32'h5A5A_1234, o);
    n_tests++;
    if ({8'(o.ncyc), o.flags, o.wbdata} !== {8'd4, 4'b1000, 32'h5A5A_1234}) begin
      n_fail++;
      $display("[TB] FAIL ack_at_timeout: got cycles=%0d flags=%b wbdata=%h expected 4/1000/5a5a1234",
               o.ncyc, o.flags, o.wbdata);
    end
  endtask

  task automatic test_misalign();
    obs_t o;
    run_op(1'b1, 1'b0, 3'b001, 32'h0000_3001, 32'h0, 0, 32'h1111_2345, o);
    n_tests++;
    if ({8'(o.ncyc), o.flags, o.wbdata} !== (TRAP ? {8'd0, 4'b1100, 32'd0} : {8'd1, 4'b1000, 32'h0000_2345})) begin
      n_fail++;
      $display("[TB] FAIL lh_misaligned: got cycles=%0d flags=%b wbdata=%h (trap build=%b)", o.ncyc, o.flags, o.wbdata, TRAP);
    end
    n_tests++;
    if (o.bus[69:32] !== (TRAP ? 38'd0 : {1'b1, 1'b0, 4'b0000, 32'h0000_3000})) begin
      n_fail++;
      $display("[TB] FAIL lh_misaligned_bus: got %h (trap build=%b)", o.bus[69:32], TRAP);
    end
  endtask

  task automatic test_reset_mid_access();
    int seen_wb;
    i_Valid_1 = 1'b1; i_MemRead_1 = 1'b1; i_MemWrite_1 = 1'b0;
    i_Funct3_3 = 3'b010; i_ALUResult_32 = 32'h0000_0500;
    @(negedge clk);
    i_Valid_1 = 1'b0;
    n_tests++;
    if (o_MemReq_1 !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midreset_req_before: got %b expected 1", o_MemReq_1);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({o_MemReq_1, o_Ready_1, o_WbValid_1} !== 3'b010) begin
      n_fail++;
      $display("[TB] FAIL midreset_async: got req/ready/wbv=%b expected 010", {o_MemReq_1, o_Ready_1, o_WbValid_1});
    end
    i_MemAck_1 = 1'b1; i_MemRdata_32 = 32'hFFFF_FFFF;
    @(negedge clk);
    i_MemAck_1 = 1'b0;
    rst_n = 1'b1;
    seen_wb = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (o_WbValid_1) seen_wb++;
    end
    n_tests++;
    if ({o_Ready_1, 8'(seen_wb)} !== {1'b1, 8'd0}) begin
      n_fail++;
      $display("[TB] FAIL midreset_after: got ready=%b writebacks=%0d expected ready=1 writebacks=0", o_Ready_1, seen_wb);
    end
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    logic rd, wr;
    logic [2:0] f3;
    logic [31:0] a, sd, rdata;
    int ack_at;
    for (int k = 0; k < 300; k++) begin
      rd = 1'($urandom); wr = 1'($urandom);
      f3 = 3'($urandom); a = $urandom; sd = $urandom; rdata = $urandom;
      ack_at = $urandom_range(0, 5);
      e = model(rd, wr, f3, a, sd, ack_at, rdata);
      run_op(rd, wr, f3, a, sd, ack_at, rdata, o);
      n_tests++;
      if ({o.ready0, 8'(o.ncyc), o.stable, o.flags, o.after} !== {1'b1, 8'(e.ncyc), 1'b1, e.flags, 2'b10}) begin
        n_fail++;
        $display("[TB] FAIL rand_ctrl #%0d rd=%b wr=%b f3=%0d a=%h ack=%0d: got ready0=%b cyc=%0d stable=%b flags=%b after=%b expected 1/%0d/1/%b/10",
                 k, rd, wr, f3, a, ack_at, o.ready0, o.ncyc, o.stable, o.flags, o.after, e.ncyc, e.flags);
      end
      if (e.ncyc > 0) begin
        n_tests++;
        if (o.bus[69:32] !== e.bus_hi) begin
          n_fail++;
          $display("[TB] FAIL rand_bus #%0d rd=%b wr=%b f3=%0d a=%h: got %h expected %h", k, rd, wr, f3, a, o.bus[69:32], e.bus_hi);
        end
        if (e.store) begin
          n_tests++;
          if (o.bus[31:0] !== e.wdata) begin
            n_fail++;
            $display("[TB] FAIL rand_wdata #%0d f3=%0d a=%h sd=%h: got %h expected %h", k, f3, a, sd, o.bus[31:0], e.wdata);
          end
        end
      end
      if (e.chk_wb) begin
        n_tests++;
        if (o.wbdata !== e.wbdata) begin
          n_fail++;
          $display("[TB] FAIL rand_wbdata #%0d rd=%b wr=%b f3=%0d a=%h rdata=%h ack=%0d: got %h expected %h",
                   k, rd, wr, f3, a, rdata, ack_at, o.wbdata, e.wbdata);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_store();
    test_load_byte();
    test_timeout();
    test_misalign();
    test_reset_mid_access();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
